matmul_sequencer: RTL and testbench

//  Control FSM for one matrix-multiply run. Streams operand rows out of the A/B operand

---
 rtl/matmul_pkg.sv | 19 +
 rtl/matmul_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: state encoding and
// the address-width helper.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Row-index width: never narrower than one bit, even for a 1x1 array.
  function automatic int calc_aw(input int max_dim);
    return (max_dim <= 2) ? 1 : $clog2(max_dim);
  endfunction

endpackage

// File: rtl/matmul_sequencer.sv
// Control FSM for one matrix-multiply run: clear, feed operands, drain, write results.
// Optional feature macro: MATMUL_SEQ_ACC_EN (accumulate mode suppresses the PE clear).
//
// state    | meaning
// ST_IDLE  | waiting for start_i; dims latched on acceptance
// ST_CLEAR | one cycle, PE accumulators cleared (unless accumulating)
// ST_FEED  | k+1 cycles streaming operand rows 0..k
// ST_DRAIN | n+m+PE_LATENCY cycles letting the PE pipeline settle
// ST_WRITE | n+1 cycles stepping result rows 0..n into the store
// ST_DONE  | one-cycle completion pulse, then back to idle
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int PE_LATENCY = 1,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int AW        = calc_aw(MAX_DIM)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          mode_acc_i,
  input  logic [AW-1:0] n_dim_i,
  input  logic [AW-1:0] k_dim_i,
  input  logic [AW-1:0] m_dim_i,
  output logic          start_send_o,
  output logic [AW-1:0] op_addr_o,
  output logic          pe_clear_o,
  output logic          pe_en_o,
  output logic          res_we_o,
  output logic [AW-1:0] res_row_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int CW = AW + 2;

  state_e          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_n;
  logic [AW-1:0]   r_k;
  logic [AW-1:0]   r_m;
  logic            r_start_send;
  logic [AW-1:0]   r_op_addr;
  logic            r_pe_clear;
  logic            r_pe_en;
  logic            r_res_we;
  logic [AW-1:0]   r_res_row;
  logic            r_busy;
  logic            r_done;

  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_feed_last;
  logic [CW-1:0]   w_drain_last;
  logic [CW-1:0]   w_write_last;
  logic            w_clear_en;

  assign w_cnt_inc    = r_cnt + CW'(1);
  assign w_feed_last  = CW'(r_k);
  assign w_write_last = CW'(r_n);
  // Drain runs n+m+PE_LATENCY cycles, so the last count value is one less.
  assign w_drain_last = CW'(r_n) + CW'(r_m) + CW'(PE_LATENCY - 1);

`ifdef MATMUL_SEQ_ACC_EN
  logic r_mode_acc;
  assign w_clear_en = ~mode_acc_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode_acc <= 1'b0;
    end else if (r_state == ST_IDLE && start_i) begin
      r_mode_acc <= mode_acc_i;
    end
  end
`else
  logic w_unused_mode_acc;
  assign w_unused_mode_acc = mode_acc_i;
  assign w_clear_en        = 1'b1;
`endif

  // Outputs are registered alongside the state, so each reflects the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_m          <= '0;
      r_start_send <= 1'b0;
      r_op_addr    <= '0;
      r_pe_clear   <= 1'b0;
      r_pe_en      <= 1'b0;
      r_res_we     <= 1'b0;
      r_res_row    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pe_clear <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (start_i) begin
            r_n        <= n_dim_i;
            r_k        <= k_dim_i;
            r_m        <= m_dim_i;
            r_state    <= ST_CLEAR;
            r_busy     <= 1'b1;
            r_pe_clear <= w_clear_en;
          end
        end
        ST_CLEAR: begin
          r_state      <= ST_FEED;
          r_cnt        <= '0;
          r_start_send <= 1'b1;
          r_pe_en      <= 1'b1;
          r_op_addr    <= '0;
        end
        ST_FEED: begin
          if (r_cnt == w_feed_last) begin
            r_state      <= ST_DRAIN;
            r_cnt        <= '0;
            r_start_send <= 1'b0;
            r_op_addr    <= '0;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_op_addr <= w_cnt_inc[AW-1:0];
          end
        end
        ST_DRAIN: begin
          if (r_cnt == w_drain_last) begin
            r_state   <= ST_WRITE;
            r_cnt     <= '0;
            r_pe_en   <= 1'b0;
            r_res_we  <= 1'b1;
            r_res_row <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_WRITE: begin
          if (r_cnt == w_write_last) begin
            r_state   <= ST_DONE;
            r_cnt     <= '0;
            r_res_we  <= 1'b0;
            r_res_row <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt     <= w_cnt_inc;
            r_res_row <= w_cnt_inc[AW-1:0];
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= '0;
          r_start_send <= 1'b0;
          r_op_addr    <= '0;
          r_pe_en      <= 1'b0;
          r_res_we     <= 1'b0;
          r_res_row    <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign start_send_o = r_start_send;
  assign op_addr_o    = r_op_addr;
  assign pe_clear_o   = r_pe_clear;
  assign pe_en_o      = r_pe_en;
  assign res_we_o     = r_res_we;
  assign res_row_o    = r_res_row;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer at default parameters (MAX_DIM=2, AW=1, PE_LATENCY=1).
// Outputs are packed as {busy, done, clear, en, send, addr, we, row} and compared per cycle.
module tb_matmul_sequencer;

  logic       clk_i;
  logic       rst_ni;
  logic       start_i;
  logic       mode_acc_i;
  logic [0:0] n_dim_i;
  logic [0:0] k_dim_i;
  logic [0:0] m_dim_i;
  logic       start_send_o;
  logic [0:0] op_addr_o;
  logic       pe_clear_o;
  logic       pe_en_o;
  logic       res_we_o;
  logic [0:0] res_row_o;
  logic       busy_o;
  logic       done_o;

  int checks;
  int errors;

  logic [7:0] obs;
  logic [7:0] exp_basic [1:10];
  logic [7:0] exp_zero  [1:6];

  matmul_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .mode_acc_i   (mode_acc_i),
    .n_dim_i      (n_dim_i),
    .k_dim_i      (k_dim_i),
    .m_dim_i      (m_dim_i),
    .start_send_o (start_send_o),
    .op_addr_o    (op_addr_o),
    .pe_clear_o   (pe_clear_o),
    .pe_en_o      (pe_en_o),
    .res_we_o     (res_we_o),
    .res_row_o    (res_row_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign obs = {busy_o, done_o, pe_clear_o, pe_en_o, start_send_o, op_addr_o, res_we_o, res_row_o};

  // Drive a start request into the next rising edge (cycle 0); leaves start_i high.
  task automatic kick(input logic [0:0] n, input logic [0:0] k, input logic [0:0] m,
                      input logic acc);
    @(negedge clk_i);
    n_dim_i    = n;
    k_dim_i    = k;
    m_dim_i    = m;
    mode_acc_i = acc;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #12;
    @(negedge clk_i);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold obs=%h exp=%h", obs, 8'h00);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_release obs=%h exp=%h", obs, 8'h00);
    end
    // Abort in the middle of FEED: outputs must drop without waiting for a clock.
    kick(1'b1, 1'b1, 1'b1, 1'b0);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (obs !== 8'h98) begin
      errors++;
      $display("FAIL reset_pre_feed obs=%h exp=%h", obs, 8'h98);
    end
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_async obs=%h exp=%h", obs, 8'h00);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d obs=%h exp=%h", c, obs, 8'h00);
      end
    end
  endtask

  task automatic test_basic;
    kick(1'b1, 1'b1, 1'b1, 1'b0);
    start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_basic[c]) begin
        errors++;
        $display("FAIL basic cyc=%0d obs=%h exp=%h", c, obs, exp_basic[c]);
      end
    end
  endtask

  task automatic test_unit_dims;
    kick(1'b0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== exp_zero[c]) begin
        errors++;
        $display("FAIL unit_dims cyc=%0d obs=%h exp=%h", c, obs, exp_zero[c]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int dones;
    int done_cyc;
    dones    = 0;
    done_cyc = -1;
    kick(1'b1, 1'b1, 1'b1, 1'b0);
    start_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      start_i = (c == 4 || c == 5);
      if (done_o === 1'b1) begin
        dones++;
        done_cyc = c;
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_start_dones obs=%0d exp=%0d", dones, 1);
    end
    checks++;
    if (done_cyc !== 9) begin
      errors++;
      $display("FAIL ignore_start_done_cycle obs=%0d exp=%0d", done_cyc, 9);
    end
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL ignore_start_idle obs=%h exp=%h", obs, 8'h00);
    end
  endtask

  task automatic test_dims_latched;
    kick(1'b1, 1'b1, 1'b1, 1'b0);
    start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (c == 2) begin
        n_dim_i = 1'b0;
        k_dim_i = 1'b0;
        m_dim_i = 1'b0;
      end
      checks++;
      if (obs !== exp_basic[c]) begin
        errors++;
        $display("FAIL dims_latched cyc=%0d obs=%h exp=%h", c, obs, exp_basic[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    // start_i stays high through DONE (cycle 5); IDLE at 6 accepts it, CLEAR at 7.
    kick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_i);
      if (c == 6) begin
        checks++;
        if (obs !== 8'h00) begin
          errors++;
          $display("FAIL b2b_idle obs=%h exp=%h", obs, 8'h00);
        end
      end
      if (c == 7) begin
        start_i = 1'b0;
        checks++;
        if (obs !== 8'hA0) begin
          errors++;
          $display("FAIL b2b_clear obs=%h exp=%h", obs, 8'hA0);
        end
      end
      if (c == 11) begin
        checks++;
        if (obs !== 8'h40) begin
          errors++;
          $display("FAIL b2b_done obs=%h exp=%h", obs, 8'h40);
        end
      end
      if (c == 12) begin
        checks++;
        if (obs !== 8'h00) begin
          errors++;
          $display("FAIL b2b_end obs=%h exp=%h", obs, 8'h00);
        end
      end
    end
  endtask

  task automatic test_acc_mode;
    int clears;
    logic exp_clr1;
`ifdef MATMUL_SEQ_ACC_EN
    exp_clr1 = 1'b0;
`else
    exp_clr1 = 1'b1;
`endif
    clears = 0;
    kick(1'b0, 1'b0, 1'b0, 1'b1);
    start_i    = 1'b0;
    mode_acc_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (pe_clear_o === 1'b1) clears++;
      if (c == 1) begin
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL acc_busy obs=%b exp=%b", busy_o, 1'b1);
        end
      end
    end
    checks++;
    if (clears !== int'(exp_clr1)) begin
      errors++;
      $display("FAIL acc_mode1_clears obs=%0d exp=%0d", clears, int'(exp_clr1));
    end
    clears = 0;
    kick(1'b0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (pe_clear_o === 1'b1) clears++;
    end
    checks++;
    if (clears !== 1) begin
      errors++;
      $display("FAIL acc_mode0_clears obs=%0d exp=%0d", clears, 1);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    start_i    = 1'b0;
    mode_acc_i = 1'b0;
    n_dim_i    = 1'b0;
    k_dim_i    = 1'b0;
    m_dim_i    = 1'b0;
    rst_ni     = 1'b1;

    // n=k=m=1, PE_LATENCY=1: CLEAR 1, FEED 2-3, DRAIN 4-6, WRITE 7-8, DONE 9.
    exp_basic[1]  = 8'hA0;
    exp_basic[2]  = 8'h98;
    exp_basic[3]  = 8'h9C;
    exp_basic[4]  = 8'h90;
    exp_basic[5]  = 8'h90;
    exp_basic[6]  = 8'h90;
    exp_basic[7]  = 8'h82;
    exp_basic[8]  = 8'h83;
    exp_basic[9]  = 8'h40;
    exp_basic[10] = 8'h00;
    // n=k=m=0: CLEAR 1, FEED 2, DRAIN 3, WRITE 4, DONE 5.
    exp_zero[1] = 8'hA0;
    exp_zero[2] = 8'h98;
    exp_zero[3] = 8'h90;
    exp_zero[4] = 8'h82;
    exp_zero[5] = 8'h40;
    exp_zero[6] = 8'h00;

    test_reset;
    test_basic;
    test_unit_dims;
    test_start_ignored;
    test_dims_latched;
    test_back_to_back;
    test_acc_mode;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
